// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver: circular store with pop handshake and sticky overrun.
// Define UART_RX_FIFO_FWFT_EN for first-word fall-through reads; otherwise reads are registered.
module uart_rx_fifo #(
    parameter int DWIDTH = 8,
    parameter int ADDR_W = 4
) (
    input  logic              I_CLK,
    input  logic              I_RSTF,
    input  logic [DWIDTH-1:0] I_WR_DATA,
    input  logic              I_WR_EN,
    input  logic              I_RD_EN,
    input  logic              I_FLUSH,
    input  logic              I_CLR_OVR,
    output logic [DWIDTH-1:0] O_RD_DATA,
    output logic              O_RD_VALID,
    output logic              O_EMPTY,
    output logic              O_FULL,
    output logic [ADDR_W:0]   O_COUNT,
    output logic              O_OVERRUN
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr, rd_ptr, count;
    logic              empty, full, rd_acc, wr_acc, ovr_set, overrun;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_V);
    assign rd_acc  = I_RD_EN & ~empty;
    // A pop in the same cycle frees the slot, so a write at full still lands.
    assign wr_acc  = I_WR_EN & (~full | rd_acc);
    assign ovr_set = I_WR_EN & ~wr_acc & ~I_FLUSH;

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (I_FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (wr_acc && !I_FLUSH) mem[wr_ptr[ADDR_W-1:0]] <= I_WR_DATA;
    end

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF)        overrun <= 1'b0;
        else if (ovr_set)   overrun <= 1'b1;
        else if (I_CLR_OVR) overrun <= 1'b0;
    end

`ifdef UART_RX_FIFO_FWFT_EN
    assign O_RD_DATA  = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
    assign O_RD_VALID = ~empty;
`else
    logic [DWIDTH-1:0] rd_data;
    logic              rd_valid;

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc & ~I_FLUSH;
            if (rd_acc && !I_FLUSH) rd_data <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    assign O_RD_DATA  = rd_data;
    assign O_RD_VALID = rd_valid;
`endif

    assign O_EMPTY   = empty;
    assign O_FULL    = full;
    assign O_COUNT   = count;
    assign O_OVERRUN = overrun;
endmodule
